// File: rtl/cpu_pkg.sv
// Shared encodings for the pipelined MIPS core: write-back source selects,
// load types and the hard-wired zero register index.
// Imported by writeback_stage and load_extender.
package cpu_pkg;

  // Write-back source select (i_mem_to_reg); 2'b11 is reserved and behaves as ALU.
  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_LINK = 2'b10;

  // Load types (i_load_type); codes 3'b101..3'b111 behave as lw.
  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  // $0 reads as zero and is never written.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_extender.sv
// Byte/halfword extract and sign/zero extension of a raw memory word.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: word (raw memory word), load_type, byte_offset (addr[1:0]) -> data.
// The selected lane is taken from the low 32 bits of word; DATA_WIDTH >= 32.
module load_extender
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [2:0]            load_type,
  input  logic [1:0]            byte_offset,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Byte lane off selects bits [8*off+7 : 8*off]; halfword uses off[1] only.
  assign sel_byte = word[{byte_offset, 3'b000} +: 8];
  assign sel_half = word[{byte_offset[1], 4'b0000} +: 16];

  always_comb begin
    data = word;
    case (load_type)
      LT_LB:   data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
      LT_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
      LT_LH:   data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
      LT_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, register-file write-port driver and ID-stage bypass.
// Latency: MEM inputs reach the write port one cycle after capture; bypass is combinational.
// Backpressure: i_stall holds the slot (repeating the same write), i_flush invalidates it.
// Ports: MEM-stage slot inputs (i_mem_valid .. i_byte_offset), ID read indices and raw
// register-file reads in; write port (o_reg_write/o_write_register/o_write_data),
// forwarded reads (o_bypass_data1/2) and o_retired_count out.
// Optional: define WB_LOAD_EXT_EN to extract/extend sub-word loads in this stage.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_mem_valid,
  input  logic                      i_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_write_register,
  input  logic [1:0]                i_mem_to_reg,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_mem_read_data,
  input  logic [DATA_WIDTH-1:0]     i_pc_plus4,
  input  logic [2:0]                i_load_type,
  input  logic [1:0]                i_byte_offset,
  input  logic [REG_ADDR_WIDTH-1:0] i_read_register1,
  input  logic [REG_ADDR_WIDTH-1:0] i_read_register2,
  input  logic [DATA_WIDTH-1:0]     i_rf_read_data1,
  input  logic [DATA_WIDTH-1:0]     i_rf_read_data2,
  output logic                      o_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] o_write_register,
  output logic [DATA_WIDTH-1:0]     o_write_data,
  output logic [DATA_WIDTH-1:0]     o_bypass_data1,
  output logic [DATA_WIDTH-1:0]     o_bypass_data2,
  output logic [CNT_WIDTH-1:0]      o_retired_count
);

  localparam logic [REG_ADDR_WIDTH-1:0] RZ = REG_ADDR_WIDTH'(REG_ZERO);

  logic                      valid_q;
  logic                      reg_write_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [1:0]                mtr_q;
  logic [DATA_WIDTH-1:0]     alu_q;
  logic [DATA_WIDTH-1:0]     mem_q;
  logic [DATA_WIDTH-1:0]     pc4_q;
  logic [2:0]                lt_q;
  logic [1:0]                off_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0]     mem_data;

  // Flush only needs to kill valid; the stale payload is harmless once valid=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      mtr_q       <= MTR_ALU;
      alu_q       <= '0;
      mem_q       <= '0;
      pc4_q       <= '0;
      lt_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (!i_stall) begin
      valid_q     <= i_mem_valid;
      reg_write_q <= i_reg_write;
      rd_q        <= i_write_register;
      mtr_q       <= i_mem_to_reg;
      alu_q       <= i_alu_result;
      mem_q       <= i_mem_read_data;
      pc4_q       <= i_pc_plus4;
      lt_q        <= i_load_type;
      off_q       <= i_byte_offset;
      // Counter wraps naturally at all-ones.
      if (i_mem_valid) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

`ifdef WB_LOAD_EXT_EN
  load_extender #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extender (
    .word        (mem_q),
    .load_type   (lt_q),
    .byte_offset (off_q),
    .data        (mem_data)
  );
`else
  // Without extension the memory word is written as-is; load type/offset are unused.
  logic unused_load_fields;
  assign unused_load_fields = ^{lt_q, off_q};
  assign mem_data = mem_q;
`endif

  always_comb begin
    o_write_data = alu_q;
    case (mtr_q)
      MTR_MEM:  o_write_data = mem_data;
      MTR_LINK: o_write_data = pc4_q;
      default:  o_write_data = alu_q;
    endcase
  end

  assign o_reg_write      = valid_q & reg_write_q & (rd_q != RZ);
  assign o_write_register = rd_q;
  assign o_retired_count  = cnt_q;

  // The register file writes on the edge, so a same-cycle read of the register
  // being written must see the new value here.
  assign o_bypass_data1 = (i_read_register1 == RZ) ? '0 :
                          (o_reg_write && (o_write_register == i_read_register1)) ? o_write_data :
                          i_rf_read_data1;
  assign o_bypass_data2 = (i_read_register2 == RZ) ? '0 :
                          (o_reg_write && (o_write_register == i_read_register2)) ? o_write_data :
                          i_rf_read_data2;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register and write-back driver for the pipelined MIPS core.
- The write-port initiator of the register file: captures the MEM-stage result, selects the write data, and drives reg_write, write register and write data.
- Also supplies write-before-read bypassing for the two ID-stage read ports, because the register file updates only on the clock edge.
- Counts retired instructions for performance debugging.

Parameters:
DATA_WIDTH, 32, datapath width
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 32, retired-instruction counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_stall  in  1  hold the WB slot
i_flush  in  1  invalidate the incoming slot
i_mem_valid  in  1  MEM slot holds a real instruction
i_reg_write  in  1  instruction writes a register
i_write_register  in  REG_ADDR_WIDTH  destination register
i_mem_to_reg  in  2  source select: 00 ALU, 01 memory, 10 link (PC+4), 11 reserved (treated as ALU)
i_alu_result  in  DATA_WIDTH  ALU result
i_mem_read_data  in  DATA_WIDTH  raw memory word
i_pc_plus4  in  DATA_WIDTH  link value
i_load_type  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
i_byte_offset  in  2  address bits [1:0]
i_read_register1  in  REG_ADDR_WIDTH  ID read index 1
i_read_register2  in  REG_ADDR_WIDTH  ID read index 2
i_rf_read_data1  in  DATA_WIDTH  register-file raw read 1
i_rf_read_data2  in  DATA_WIDTH  register-file raw read 2
o_reg_write  out  1  register-file write enable
o_write_register  out  REG_ADDR_WIDTH  register-file write index
o_write_data  out  DATA_WIDTH  register-file write data
o_bypass_data1  out  DATA_WIDTH  forwarded read 1
o_bypass_data2  out  DATA_WIDTH  forwarded read 2
o_retired_count  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high.
  - Clears all slot fields: valid=0, reg_write=0, rd=0, mem_to_reg=00, all data fields 0, counter=0.
  - Outputs during and after reset: o_reg_write=0, o_write_register=0, o_write_data=0, o_retired_count=0.
  - Reset mid-operation discards the slot with no write.
- Capture (posedge clk): priority is reset > flush > stall > load.
  - i_flush: slot valid <= 0 (other fields don't-care); overrides i_stall.
  - i_stall (no flush): slot holds all fields.
  - Otherwise: all inputs are registered; valid <= i_mem_valid.
- Latency: MEM inputs appear on the register-file write port 1 cycle after capture.
- Write port:
  - o_reg_write = valid & reg_write & (rd != 0).
  - o_write_register = rd.
  - o_write_data = combinational mux of the registered fields.
- Stall repeats an identical write each cycle; this is idempotent and permitted.
- Bypass, per port N:
  - index 0 -> 0;
  - else if o_reg_write and o_write_register == i_read_registerN -> o_write_data;
  - else i_rf_read_data N.
  - Purely combinational; both ports may match the same register.
- Retired counter:
  - Increments on a capture cycle (no reset, no flush, no stall) with i_mem_valid=1.
  - Wraps from all-ones to 0.
  - Stall and flush cycles never increment it.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- Defined: when mem_to_reg=01, the memory word is extracted/extended in WB:
  - lb/lbu select byte [8*off+7:8*off], sign-/zero-extended;
  - lh/lhu select halfword off[1] (off[0] ignored), sign-/zero-extended;
  - lw and codes 101-111 pass the word unchanged.
- Undefined: i_load_type and i_byte_offset are ignored; the memory word passes unchanged. The ports exist in both builds.

Decomposition:
- Shared package, cpu_pkg:
  - mem_to_reg encodings (MTR_ALU, MTR_MEM, MTR_LINK);
  - load-type encodings;
  - REG_ZERO constant.
- One natural sub-module, load_extender: combinational byte/halfword extract and extend, instantiated only under WB_LOAD_EXT_EN.

Test Plan:
- Reset then ALU write:
  - Stimulus: reset pulse; then capture valid, reg_write, rd=8, mtr=00, alu=0x0000_1234.
  - Response: next cycle o_reg_write=1, o_write_register=8, o_write_data=0x0000_1234, o_retired_count=1.
- Write to $0:
  - Stimulus: valid, reg_write, rd=0, alu=0xFFFF_FFFF.
  - Response: o_reg_write=0; read_register1=0 gives o_bypass_data1=0.
- Link and bypass:
  - Stimulus: rd=31, mtr=10, pc+4=0x0040_0010; read_register1=read_register2=31, rf data=0xDEAD_BEEF.
  - Response: both bypass outputs = 0x0040_0010; with read_register2=5, o_bypass_data2=0xDEAD_BEEF.
- Stall then flush:
  - Stimulus: load rd=9 alu=0x11; assert stall 3 cycles while inputs change to alu=0x22; then assert flush and stall together.
  - Response: 0x11 held and written each stalled cycle, count unchanged at 1; after flush o_reg_write=0 and count still 1.
- Load extension (WB_LOAD_EXT_EN):
  - Stimulus: mem=0x80FF_7F01, mtr=01.
  - Response: lb off=3 -> 0xFFFF_FF80; lbu off=2 -> 0x0000_00FF; lh off=2 -> 0xFFFF_80FF; lhu off=0 -> 0x0000_7F01.
  - Without the macro, all four cases -> 0x80FF_7F01.
- Counter wrap and async reset:
  - Stimulus: force the counter to all-ones and capture one valid instruction; then assert reset between clock edges.
  - Response: count becomes 0 after the capture; outputs clear to 0 immediately on reset, with no edge required.
